// File: rtl/clk_pkg.sv
// clk_pkg
//   Shared definitions for the clock/timer datapath counters.
//   - bcd_digit_t : one packed BCD digit (4 bits)
//   - BCD_ZERO / BCD_NINE : digit limits
//   - MAX_DIGITS  : widest counter the helper functions support
//   - to_bcd()    : constant function, decimal integer -> packed BCD
//                   (digit 0 in bits [3:0]), MAX_DIGITS digits wide
//   - pow10()     : constant function, 10**n
package clk_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_ZERO = 4'd0;
   localparam bcd_digit_t BCD_NINE = 4'd9;

   // 10**9 still fits an int unsigned, which bounds the digit count.
   localparam int unsigned MAX_DIGITS = 9;

   function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int unsigned val);
      logic [4*MAX_DIGITS-1:0] r;
      int unsigned             v;
      r = '0;
      v = val;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v           = v / 10;
      end
      return r;
   endfunction

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// bcd_mod_counter_if
//   Request/response bundle of one BCD modulus counter stage.
//   master : clr, load, load_val, increase, decrease out; value, over,
//            under, load_err in (the controller / upstream stage side)
//   slave  : the counter itself
//   N_DIGITS sets the width of load_val / value (4*N_DIGITS bits).
interface bcd_mod_counter_if #(
   parameter int unsigned N_DIGITS = 2
);

   logic                    clr;
   logic                    load;
   logic [4*N_DIGITS-1:0]   load_val;
   logic                    increase;
   logic                    decrease;
   logic [4*N_DIGITS-1:0]   value;
   logic                    over;
   logic                    under;
   logic                    load_err;

   modport master (
      output clr, load, load_val, increase, decrease,
      input  value, over, under, load_err
   );

   modport slave (
      input  clr, load, load_val, increase, decrease,
      output value, over, under, load_err
   );

endinterface

// File: rtl/bcd_digit.sv
// bcd_digit
//   One registered 0-9 BCD digit of a cascaded counter.
//   clk_out, rst_n : clock, asynchronous active-low reset to INIT_DIGIT
//   clr            : synchronous clear to 0 (highest priority)
//   ld, ld_digit   : synchronous parallel load
//   wrap, wrap_digit : forced value used by the top for the terminal wrap
//   inc, dec       : step up / down this cycle
//   digit          : registered digit
//   carry, borrow  : combinational ripple to the next digit (inc at 9,
//                    dec at 0)
module bcd_digit
   import clk_pkg::*;
#(
   parameter bcd_digit_t INIT_DIGIT = BCD_ZERO
) (
   input  logic       clk_out,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       ld,
   input  bcd_digit_t ld_digit,
   input  logic       wrap,
   input  bcd_digit_t wrap_digit,
   input  logic       inc,
   input  logic       dec,
   output bcd_digit_t digit,
   output logic       carry,
   output logic       borrow
);

   assign carry  = inc & (digit == BCD_NINE);
   assign borrow = dec & (digit == BCD_ZERO);

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         digit <= INIT_DIGIT;
      end else if (clr) begin
         digit <= BCD_ZERO;
      end else if (ld) begin
         digit <= ld_digit;
      end else if (wrap) begin
         digit <= wrap_digit;
      end else if (inc) begin
         digit <= (digit == BCD_NINE) ? BCD_ZERO : digit + 4'd1;
      end else if (dec) begin
         digit <= (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Multi-digit BCD up/down counter wrapping at MOD_VAL.
//   clk_out : clock, rising edge
//   rst_n   : asynchronous active-low reset, value <= BCD(INIT_VAL)
//   bus     : bcd_mod_counter_if.slave
//             clr, load, load_val, increase, decrease in;
//             value (registered), over/under (combinational carry/borrow),
//             load_err (registered one-cycle pulse on a rejected load) out
//   Priority per edge: clr > load > count.
//   Build option: define BCD_MOD_COUNTER_SAT_EN to saturate at 0 and
//   MOD_VAL-1 instead of wrapping; over/under still flag the limit.
module bcd_mod_counter
   import clk_pkg::*;
#(
   parameter int unsigned N_DIGITS = 2,
   parameter int unsigned MOD_VAL  = 60,
   parameter int unsigned INIT_VAL = 0
) (
   input  logic             clk_out,
   input  logic             rst_n,
   bcd_mod_counter_if.slave bus
);

   localparam int unsigned              W         = 4 * N_DIGITS;
   localparam logic [4*MAX_DIGITS-1:0]  MAX_FULL  = to_bcd(MOD_VAL - 1);
   localparam logic [4*MAX_DIGITS-1:0]  INIT_FULL = to_bcd(INIT_VAL);
   localparam logic [W-1:0]             MAX_BCD   = MAX_FULL[W-1:0];
   localparam logic [W-1:0]             INIT_BCD  = INIT_FULL[W-1:0];

   if (N_DIGITS == 0 || N_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $fatal(1, "bcd_mod_counter: N_DIGITS out of range");
   end
   if (MOD_VAL < 2 || MOD_VAL > pow10(N_DIGITS)) begin : g_bad_mod
      $fatal(1, "bcd_mod_counter: MOD_VAL out of range");
   end
   if (INIT_VAL >= MOD_VAL) begin : g_bad_init
      $fatal(1, "bcd_mod_counter: INIT_VAL must be below MOD_VAL");
   end

   logic [W-1:0]        value_q;
   logic                load_err_q;
   logic                digits_ok;
   logic                load_ok;
   logic                load_go;
   logic                accept;
   logic                up_req;
   logic                dn_req;
   logic                at_top;
   logic                at_zero;
   logic                over_c;
   logic                under_c;
   logic                step_up;
   logic                step_dn;
   logic                wrap;
   logic [W-1:0]        wrap_val;
   logic [N_DIGITS:0]   inc_en;
   logic [N_DIGITS:0]   dec_en;
   logic                chain_unused;

   always_comb begin
      digits_ok = 1'b1;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (bus.load_val[4*i +: 4] > BCD_NINE) begin
            digits_ok = 1'b0;
         end
      end
   end

   // With every digit valid, an unsigned compare of the packed BCD
   // vectors orders them exactly as their decimal values.
   assign load_ok = digits_ok & (bus.load_val <= MAX_BCD);
   assign load_go = ~bus.clr & bus.load & load_ok;

   assign accept  = ~bus.clr & ~bus.load;
   assign up_req  = bus.increase & ~bus.decrease;
   assign dn_req  = bus.decrease & ~bus.increase;
   assign at_top  = (value_q == MAX_BCD);
   assign at_zero = (value_q == '0);

   assign over_c  = accept & up_req & at_top;
   assign under_c = accept & dn_req & at_zero;

   // The terminal step is handled as a forced load of every digit, so the
   // digit ripple chain only ever sees non-terminal steps.
   assign step_up = accept & up_req & ~at_top;
   assign step_dn = accept & dn_req & ~at_zero;

`ifdef BCD_MOD_COUNTER_SAT_EN
   assign wrap     = 1'b0;
   assign wrap_val = '0;
`else
   assign wrap     = over_c | under_c;
   assign wrap_val = under_c ? MAX_BCD : '0;
`endif

   assign inc_en[0] = step_up;
   assign dec_en[0] = step_dn;

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
      bcd_digit #(
         .INIT_DIGIT (INIT_BCD[4*i +: 4])
      ) u_digit (
         .clk_out    (clk_out),
         .rst_n      (rst_n),
         .clr        (bus.clr),
         .ld         (load_go),
         .ld_digit   (bus.load_val[4*i +: 4]),
         .wrap       (wrap),
         .wrap_digit (wrap_val[4*i +: 4]),
         .inc        (inc_en[i]),
         .dec        (dec_en[i]),
         .digit      (value_q[4*i +: 4]),
         .carry      (inc_en[i+1]),
         .borrow     (dec_en[i+1])
      );
   end

   // Ripple out of the top digit cannot fire: non-terminal steps never
   // pass MOD_VAL-1 or go below 0.
   assign chain_unused = inc_en[N_DIGITS] | dec_en[N_DIGITS];

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= ~bus.clr & bus.load & ~load_ok;
      end
   end

   assign bus.value    = value_q;
   assign bus.over     = over_c;
   assign bus.under    = under_c;
   assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter
//   Scoreboard bench for bcd_mod_counter (N_DIGITS=2, MOD_VAL=60,
//   INIT_VAL=12). The stimulus process pushes the expected per-cycle
//   response from a decimal integer model; a negedge monitor pops and
//   compares value, load_err, over and under.
module tb_bcd_mod_counter;

   localparam int N    = 2;
   localparam int MOD  = 60;
   localparam int INIT = 12;

   typedef struct {
      logic [7:0] value;
      logic       err;
      logic       over;
      logic       under;
   } exp_t;

   logic clk_out;
   logic rst_n;

   bcd_mod_counter_if #(.N_DIGITS(N)) bus ();

   bcd_mod_counter #(
      .N_DIGITS (N),
      .MOD_VAL  (MOD),
      .INIT_VAL (INIT)
   ) dut (
      .clk_out (clk_out),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cnt;
   bit   err_m;

   initial clk_out = 1'b0;
   always #5 clk_out = ~clk_out;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of requests; record what the DUT must show during it
   // and advance the decimal model across the coming edge.
   task automatic drive(input bit c, input bit l, input logic [7:0] lv, input bit i, input bit d);
      exp_t e;
      bit   up, dn, acc, valid;
      int   hi, lo;
      @(posedge clk_out);
      #1;
      bus.clr      = c;
      bus.load     = l;
      bus.load_val = lv;
      bus.increase = i;
      bus.decrease = d;
      acc     = !c && !l;
      up      = i && !d;
      dn      = d && !i;
      e.value = bcd8(cnt);
      e.err   = err_m;
      e.over  = acc && up && (cnt == MOD - 1);
      e.under = acc && dn && (cnt == 0);
      sbq.push_back(e);
      hi    = int'(lv[7:4]);
      lo    = int'(lv[3:0]);
      valid = (hi <= 9) && (lo <= 9) && (hi * 10 + lo < MOD);
      err_m = 1'b0;
      if (c) begin
         cnt = 0;
      end else if (l) begin
         if (valid) cnt = hi * 10 + lo;
         else       err_m = 1'b1;
      end else if (up) begin
`ifdef BCD_MOD_COUNTER_SAT_EN
         if (cnt < MOD - 1) cnt = cnt + 1;
`else
         cnt = (cnt + 1) % MOD;
`endif
      end else if (dn) begin
`ifdef BCD_MOD_COUNTER_SAT_EN
         if (cnt > 0) cnt = cnt - 1;
`else
         cnt = (cnt + MOD - 1) % MOD;
`endif
      end
   endtask

   always @(negedge clk_out) begin
      exp_t e;
      if (rst_n === 1'b1 && sbq.size() > 0) begin
         e = sbq.pop_front();
         check("value",    32'(bus.value),    32'(e.value));
         check("load_err", 32'(bus.load_err), 32'(e.err));
         check("over",     32'(bus.over),     32'(e.over));
         check("under",    32'(bus.under),    32'(e.under));
      end
   end

   initial begin
      logic [7:0] lv;
      int         r;
      rst_n        = 1'b0;
      bus.clr      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.increase = 1'b0;
      bus.decrease = 1'b0;
      cnt          = INIT;
      err_m        = 1'b0;
      repeat (2) @(posedge clk_out);
      #1;
      check("reset_value", 32'(bus.value), 32'(bcd8(INIT)));
      check("reset_err",   32'(bus.load_err), 32'h0);
      rst_n = 1'b1;

      // up count through the wrap
      drive(1, 0, 8'h00, 0, 0);
      repeat (60) drive(0, 0, 8'h00, 1, 0);
      // digit ripple up and down
      drive(0, 1, 8'h09, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 0, 1);
      // down wrap, then both requests together
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 0, 8'h00, 0, 1);
      drive(0, 0, 8'h00, 1, 1);
      // loads: valid, out of range, non-BCD, then idle
      drive(0, 1, 8'h42, 0, 0);
      drive(0, 1, 8'h75, 0, 0);
      drive(0, 1, 8'h3A, 0, 0);
      drive(0, 0, 8'h00, 0, 0);
      drive(0, 1, 8'h60, 1, 0);
      drive(0, 1, 8'h59, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      // priority: clr beats load beats count
      drive(1, 1, 8'h42, 1, 0);
      drive(0, 1, 8'h00, 0, 1);
      drive(0, 0, 8'h00, 0, 0);
      repeat (5) drive(0, 0, 8'h00, 1, 0);

      // asynchronous reset in the middle of a cycle
      @(posedge clk_out);
      #1;
      bus.increase = 1'b0;
      bus.load     = 1'b0;
      bus.clr      = 1'b0;
      bus.decrease = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_value", 32'(bus.value), 32'(bcd8(INIT)));
      check("async_reset_err",   32'(bus.load_err), 32'h0);
      @(posedge clk_out);
      #1;
      rst_n = 1'b1;
      cnt   = INIT;
      err_m = 1'b0;
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 0, 1);

      // randomized traffic
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(1) == 0) lv = bcd8(int'($urandom_range(MOD - 1)));
         else                        lv = 8'($urandom_range(255));
         r = int'($urandom_range(7));
         drive($urandom_range(15) == 0, $urandom_range(7) == 0, lv,
               (r == 1 || r == 2 || r == 3 || r == 7),
               (r == 4 || r == 5 || r == 6 || r == 7));
      end
      drive(0, 0, 8'h00, 0, 0);

      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk_out);
      if (sbq.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expected responses never checked", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
